// File: rtl/sysmgr_reboot_if.sv
// Reboot request / warmboot control bundle between a system manager and sysmgr_reboot.
// The master drives requests; the slave (sysmgr_reboot) drives the warmboot and status outputs.
interface sysmgr_reboot_if;
  logic       req_stb;
  logic [1:0] req_sel;
  logic       cancel;
  logic [1:0] wb_sel;
  logic       wb_boot;
  logic       armed;
  logic       pending;

  modport master (
    output req_stb,
    output req_sel,
    output cancel,
    input  wb_sel,
    input  wb_boot,
    input  armed,
    input  pending
  );

  modport slave (
    input  req_stb,
    input  req_sel,
    input  cancel,
    output wb_sel,
    output wb_boot,
    output armed,
    output pending
  );
endinterface

// File: rtl/sysmgr_reboot.sv
// Two-strobe confirmed reboot sequencer driving a warmboot primitive.
// A request must be repeated with the same image index before the boot fires after a fixed delay.
module sysmgr_reboot #(
  parameter int unsigned ARM_TIMEOUT  = 16777216,
  parameter int unsigned DELAY_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  sysmgr_reboot_if.slave      reboot_io
);

  localparam int unsigned TmoW = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int unsigned DlyW = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(ARM_TIMEOUT - 1);
  localparam logic [DlyW-1:0] DlyLoad = DlyW'(DELAY_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StWait, StBoot} state_e;

  state_e          state_q;
  logic [1:0]      sel_q;
  logic [TmoW-1:0] tmo_q;
  logic [DlyW-1:0] dly_q;
  logic [1:0]      wb_sel_q;
  logic            wb_boot_q;
  logic            armed_q;
  logic            pending_q;

  // Outputs are set alongside each state transition so they are registered copies of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      tmo_q     <= '0;
      dly_q     <= '0;
      wb_sel_q  <= '0;
      wb_boot_q <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (reboot_io.req_stb && !reboot_io.cancel) begin
            sel_q   <= reboot_io.req_sel;
            tmo_q   <= TmoLoad;
            armed_q <= 1'b1;
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (reboot_io.cancel) begin
            armed_q <= 1'b0;
            state_q <= StIdle;
          end else if (reboot_io.req_stb && (reboot_io.req_sel == sel_q)) begin
            // Confirmation beats timeout expiry in the final armed cycle.
            dly_q     <= DlyLoad;
            armed_q   <= 1'b0;
            pending_q <= 1'b1;
            wb_sel_q  <= sel_q;
            state_q   <= StWait;
          end else if (reboot_io.req_stb) begin
            sel_q <= reboot_io.req_sel;
            tmo_q <= TmoLoad;
          end else if (tmo_q == '0) begin
            armed_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q - TmoW'(1);
          end
        end
        StWait: begin
          if (reboot_io.cancel) begin
            pending_q <= 1'b0;
            wb_sel_q  <= '0;
            state_q   <= StIdle;
          end else if (dly_q == '0) begin
            pending_q <= 1'b0;
            wb_boot_q <= 1'b1;
            state_q   <= StBoot;
          end else begin
            dly_q <= dly_q - DlyW'(1);
          end
        end
        StBoot: begin
          state_q <= StBoot;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign reboot_io.wb_sel  = wb_sel_q;
  assign reboot_io.wb_boot = wb_boot_q;
  assign reboot_io.armed   = armed_q;
  assign reboot_io.pending = pending_q;

endmodule

// File: tb/tb_sysmgr_reboot.sv
// Directed bench for sysmgr_reboot with ARM_TIMEOUT=16, DELAY_CYCLES=8.
// Cycle n inputs are applied 1ns after edge n and sampled at edge n+1; outputs read 1ns after.
module tb_sysmgr_reboot;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sysmgr_reboot_if rb_if ();

  sysmgr_reboot #(
    .ARM_TIMEOUT (16),
    .DELAY_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reboot_io(rb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rb_if.req_stb = 1'b0;
    rb_if.req_sel = 2'd0;
    rb_if.cancel  = 1'b0;
  endtask

  task automatic run(input int n);
    idle_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [1:0] sel, input logic cxl);
    rb_if.req_stb = 1'b1;
    rb_if.req_sel = sel;
    rb_if.cancel  = cxl;
    tick();
    idle_in();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic a, input logic p, input logic b,
                         input logic [1:0] s);
    chk({tag, ".armed"},   32'(rb_if.armed),   32'(a));
    chk({tag, ".pending"}, 32'(rb_if.pending), 32'(p));
    chk({tag, ".wb_boot"}, 32'(rb_if.wb_boot), 32'(b));
    chk({tag, ".wb_sel"},  32'(rb_if.wb_sel),  32'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    tick();
    do_reset();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);

    // Confirm at 5: armed 1-5, pending 6-13, boot from 14.
    strobe(2'd2, 1'b0);                       // cycle 0 -> now 1
    chk_out("c28_c1", 1'b1, 1'b0, 1'b0, 2'd0);
    run(4);                                   // now 5
    chk_out("c28_c5", 1'b1, 1'b0, 1'b0, 2'd0);
    strobe(2'd2, 1'b0);                       // now 6
    chk_out("c28_c6", 1'b0, 1'b1, 1'b0, 2'd2);
    run(7);                                   // now 13
    chk_out("c28_c13", 1'b0, 1'b1, 1'b0, 2'd2);
    tick();                                   // now 14
    chk_out("c28_c14", 1'b0, 1'b0, 1'b1, 2'd2);
    strobe(2'd1, 1'b1);                       // BOOT ignores strobe and cancel
    chk_out("boot_hold", 1'b0, 1'b0, 1'b1, 2'd2);
    do_reset();
    chk_out("rst_boot", 1'b0, 1'b0, 1'b0, 2'd0);

    // Single strobe times out: armed 1-16, idle 17.
    strobe(2'd1, 1'b0);                       // now 1
    run(15);                                  // now 16
    chk_out("c29_c16", 1'b1, 1'b0, 1'b0, 2'd0);
    tick();                                   // now 17
    chk_out("c29_c17", 1'b0, 1'b0, 1'b0, 2'd0);
    run(12);
    chk_out("c29_late", 1'b0, 1'b0, 1'b0, 2'd0);

    // Re-latch at 4 reloads timeout; confirm at 20 accepted, boot at 29 with sel 3.
    strobe(2'd1, 1'b0);                       // now 1
    run(3);                                   // now 4
    strobe(2'd3, 1'b0);                       // now 5
    chk_out("c30_c5", 1'b1, 1'b0, 1'b0, 2'd0);
    run(15);                                  // now 20
    chk_out("c30_c20", 1'b1, 1'b0, 1'b0, 2'd0);
    strobe(2'd3, 1'b0);                       // now 21
    chk_out("c30_c21", 1'b0, 1'b1, 1'b0, 2'd3);
    run(7);                                   // now 28
    chk_out("c30_c28", 1'b0, 1'b1, 1'b0, 2'd3);
    tick();                                   // now 29
    chk_out("c30_c29", 1'b0, 1'b0, 1'b1, 2'd3);
    do_reset();

    // Confirm at 3, cancel at 7 drops pending at 8.
    strobe(2'd1, 1'b0);                       // now 1
    run(2);                                   // now 3
    strobe(2'd1, 1'b0);                       // now 4
    run(3);                                   // now 7
    chk_out("c31_c7", 1'b0, 1'b1, 1'b0, 2'd1);
    rb_if.cancel = 1'b1;
    tick();                                   // now 8
    chk_out("c31_c8", 1'b0, 1'b0, 1'b0, 2'd0);
    run(12);
    chk_out("c31_late", 1'b0, 1'b0, 1'b0, 2'd0);

    // Cancel wins over a simultaneous confirming strobe in ARMED.
    strobe(2'd2, 1'b0);
    chk_out("cx_armed", 1'b1, 1'b0, 1'b0, 2'd0);
    strobe(2'd2, 1'b1);
    chk_out("cx_stb", 1'b0, 1'b0, 1'b0, 2'd0);
    // Strobe with cancel in IDLE is ignored.
    strobe(2'd2, 1'b1);
    chk_out("idle_cx", 1'b0, 1'b0, 1'b0, 2'd0);

    // Confirmation in the last armed cycle wins over expiry.
    strobe(2'd3, 1'b0);                       // now 1
    run(15);                                  // now 16
    chk_out("c33_c16", 1'b1, 1'b0, 1'b0, 2'd0);
    strobe(2'd3, 1'b0);                       // now 17
    chk_out("c33_c17", 1'b0, 1'b1, 1'b0, 2'd3);

    // Reset mid-WAIT, then reach BOOT, reset there, then a fresh sequence.
    run(2);
    do_reset();
    chk_out("rst_wait", 1'b0, 1'b0, 1'b0, 2'd0);
    strobe(2'd1, 1'b0);                       // now 1
    strobe(2'd1, 1'b0);                       // now 2
    run(8);                                   // now 10
    chk_out("c32_boot", 1'b0, 1'b0, 1'b1, 2'd1);
    do_reset();
    chk_out("c32_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    strobe(2'd2, 1'b0);
    strobe(2'd2, 1'b0);
    chk_out("fresh_wait", 1'b0, 1'b1, 1'b0, 2'd2);
    run(8);
    chk_out("fresh_boot", 1'b0, 1'b0, 1'b1, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sysmgr_reboot.md
SYSMGR_REBOOT -- requirements
Module: sysmgr_reboot

Interface
REQ-001 SHALL have parameter ARM_TIMEOUT, default 16777216, number of cycles an arm request stays valid (>=2).
REQ-002 SHALL have parameter DELAY_CYCLES, default 4096, cycles from confirmation to boot assertion (>=1).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_stb  input  1  one-cycle reboot request strobe.
REQ-006 SHALL have port req_sel  input  2  boot image index, sampled with req_stb.
REQ-007 SHALL have port cancel  input  1  abort a pending request; level, sampled every cycle.
REQ-008 SHALL have port wb_sel  output  2  image select to warmboot primitive.
REQ-009 SHALL have port wb_boot  output  1  boot trigger to warmboot primitive.
REQ-010 SHALL have port armed  output  1  high while first request awaits confirmation.
REQ-011 SHALL have port pending  output  1  high during post-confirmation delay.

Function
REQ-012 SHALL implement states IDLE, ARMED, WAIT, BOOT; all outputs registered.
REQ-013 IDLE: req_stb SHALL latch req_sel into sel register, load timeout counter, enter ARMED next cycle.
REQ-014 ARMED: req_stb with req_sel equal to latched sel SHALL enter WAIT next cycle, loading delay counter with DELAY_CYCLES-1.
REQ-015 ARMED: req_stb with different req_sel SHALL re-latch sel, reload timeout, stay ARMED.
REQ-016 ARMED SHALL last exactly ARM_TIMEOUT cycles without confirmation, then return to IDLE.
REQ-017 Confirmation strobe in the last ARMED cycle SHALL win over timeout expiry.
REQ-018 cancel high in ARMED or WAIT SHALL return to IDLE next cycle; cancel SHALL win over simultaneous req_stb.
REQ-019 WAIT: delay counter SHALL decrement each cycle; at zero SHALL enter BOOT next cycle; req_stb ignored.
REQ-020 BOOT SHALL be terminal until rst; req_stb and cancel ignored.
REQ-021 wb_sel SHALL equal latched sel in WAIT and BOOT, 0 otherwise; thus stable >= DELAY_CYCLES cycles before wb_boot rises.
REQ-022 wb_boot SHALL be 1 only in BOOT; armed only in ARMED; pending only in WAIT.
REQ-023 Confirmation accepted at cycle m SHALL give pending=1 from m+1 and wb_boot=1 from m+1+DELAY_CYCLES.
REQ-024 Counters SHALL be sized by $clog2 of their parameter and never wrap.
REQ-025 req_stb in IDLE with cancel high SHALL be ignored (stay IDLE).

Reset
REQ-026 rst SHALL force IDLE, sel=0, counters=0, wb_sel=0, wb_boot=0, armed=0, pending=0 on the next clk edge.
REQ-027 rst SHALL take priority over every input, including in BOOT and mid-WAIT.

Verification (ARM_TIMEOUT=16, DELAY_CYCLES=8)
REQ-028 req_stb sel=2 at cycle 0, again sel=2 at cycle 5 -> armed cycles 1-5, pending cycles 6-13, wb_boot=1 and wb_sel=2 from cycle 14.
REQ-029 single req_stb sel=1 at cycle 0 -> armed cycles 1-16, IDLE at 17, wb_boot stays 0.
REQ-030 req_stb sel=1 at 0, sel=3 at 4, sel=3 at 20 -> confirmation accepted (timeout reloaded at 4), wb_boot=1 from cycle 29 with wb_sel=3.
REQ-031 confirm at 0/3, cancel at cycle 7 -> pending drops at 8, wb_sel=0, wb_boot never rises; cancel+req_stb same cycle in ARMED -> IDLE.
REQ-032 rst asserted in WAIT and again in BOOT -> all outputs 0 next cycle; fresh request sequence afterwards completes normally.
REQ-033 confirmation strobe on cycle 16 after arm at 0 -> accepted, pending=1 at 17.
